// File: rtl/mem_mp_pkg.sv
// mem_mp_pkg: shared constants, port-index type and round-robin grant function
package mem_mp_pkg;
  localparam int MAX_PORTS = 8;
  localparam int MAX_RD_LATENCY = 4;
  typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;
  function automatic logic [MAX_PORTS-1:0] rr_grant(input logic [MAX_PORTS-1:0] req, input port_idx_t ptr, input int n);
    logic [MAX_PORTS-1:0] g;
    int j;
    g = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      j = int'(ptr) + i;
      j = (j >= n) ? j - n : j;
      if (i < n && g == '0 && req[j]) g[j] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/mem_mp_arb_rr.sv
// rr_arbiter: one-hot round-robin grant over N requesters, owns the search pointer
module rr_arbiter
  import mem_mp_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] gnt_o
);
  port_idx_t ptr_q, ptr_d, idx;
  logic [MAX_PORTS-1:0] req_ext, gnt_ext;
  always_comb begin
    req_ext = '0;
    req_ext[N-1:0] = req_i;
    gnt_ext = rr_grant(req_ext, ptr_q, N);
    gnt_o = gnt_ext[N-1:0];
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) if (gnt_ext[i]) idx = port_idx_t'(i);
    ptr_d = !accept_i ? ptr_q : (int'(idx) == N - 1) ? '0 : idx + 1'b1;
  end
  always_ff @(posedge clk_i) ptr_q <= rst_i ? '0 : ptr_d;
endmodule

// File: rtl/mem_mp_arb.sv
// mem_mp_arb: multi-port round-robin scratchpad with byte enables and pipelined reads
module mem_mp_arb
  import mem_mp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int NUM_PORTS = 2,
  parameter int RD_LATENCY = 1,
  parameter int CLEAR_ON_RST = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BE_WIDTH = WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            valid_i,
  input  logic [NUM_PORTS-1:0]            wr_rd_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*WIDTH-1:0]      wdata_i,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]   be_i,
  output logic [NUM_PORTS-1:0]            ready_o,
  output logic [WIDTH-1:0]                rdata_o,
  output logic [NUM_PORTS-1:0]            rvalid_o
);
  logic [NUM_PORTS-1:0] gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata, rd_word;
  logic [BE_WIDTH-1:0] be;
  logic wr, acc, rd_acc;
  port_idx_t sel;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [RD_LATENCY-1:0] pv_q;
  port_idx_t pp_q [RD_LATENCY];
  logic [WIDTH-1:0] pd_q [RD_LATENCY];
  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk_i,
    .rst_i,
    .req_i(valid_i),
    .accept_i(acc),
    .gnt_o(gnt)
  );
  assign ready_o = gnt & {NUM_PORTS{~rst_i}};
  assign acc = |ready_o;
  assign rd_acc = acc & ~wr;
  assign rdata_o = pd_q[RD_LATENCY-1];
  always_comb begin
    sel = '0;
    wr = 1'b0;
    addr = '0;
    wdata = '0;
    be = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (gnt[i]) begin
        sel = port_idx_t'(i);
        wr = wr_rd_i[i];
        addr = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata = wdata_i[i*WIDTH +: WIDTH];
        be = be_i[i*BE_WIDTH +: BE_WIDTH];
      end
    rd_word = (int'(addr) < DEPTH) ? mem_q[addr] : '0;
    for (int i = 0; i < NUM_PORTS; i++) rvalid_o[i] = pv_q[RD_LATENCY-1] && pp_q[RD_LATENCY-1] == port_idx_t'(i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i && CLEAR_ON_RST != 0)
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (acc && wr && int'(addr) < DEPTH)
      for (int b = 0; b < BE_WIDTH; b++) if (be[b]) mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
  end
  // data stages only advance behind a valid token, so the last stage holds the last delivered word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        pp_q[s] <= '0;
        pd_q[s] <= '0;
      end
    end else begin
      pv_q[0] <= rd_acc;
      if (rd_acc) begin
        pp_q[0] <= sel;
        pd_q[0] <= rd_word;
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        pv_q[s] <= pv_q[s-1];
        if (pv_q[s-1]) begin
          pp_q[s] <= pp_q[s-1];
          pd_q[s] <= pd_q[s-1];
        end
      end
    end
  end
endmodule
